// File: rtl/hci_parity_fault_collector.sv
// hci_parity_fault_collector
//   Collects the registered fault pulses of the HCI parity sinks. It keeps a
//   sticky flag and a saturating event counter per sink, a saturating total,
//   and the index of the first sink that faulted. It raises an interrupt on
//   the first fault and an escalation flag once the total reaches
//   ESC_THRESHOLD. clear_i acknowledges and wipes all status.
//
// Ports
//   clk_i, rst_ni   clock, async active-low reset
//   fault_i         per-sink fault pulse (bit i = sink i)
//   mask_i          per-sink, per-cycle ignore
//   clear_i         single-cycle acknowledge
//   irq_o           level interrupt (FAULT or ESCALATED)
//   escalate_o      level escalation (ESCALATED)
//   sticky_o        per-sink sticky fault flags
//   first_valid_o   first_idx_o is valid
//   first_idx_o     lowest faulting index of the first faulting cycle
//   total_cnt_o     saturating total of unmasked fault events
//   sink_cnt_o      per-sink saturating counters, sink i at [i*CNT_W +: CNT_W]

// Per-sink slice: sticky flag plus saturating event counter.
module hci_parity_fault_collector_sink #(
  parameter int CNT_W = 8
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             clear_i,
  input  logic             fault_i,   // already masked
  output logic             sticky_o,
  output logic [CNT_W-1:0] cnt_o
);
  logic             sticky_nxt;
  logic [CNT_W-1:0] cnt_nxt;

  // Clear acts first, then this cycle's fault lands on the cleared value.
  always_comb begin
    sticky_nxt = (clear_i ? 1'b0 : sticky_o) | fault_i;
    cnt_nxt    = clear_i ? '0 : cnt_o;
    if (fault_i && (cnt_nxt != '1)) cnt_nxt = cnt_nxt + 1'b1;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sticky_o <= 1'b0;
      cnt_o    <= '0;
    end else begin
      sticky_o <= sticky_nxt;
      cnt_o    <= cnt_nxt;
    end
  end
endmodule

module hci_parity_fault_collector #(
  parameter int N_SINKS       = 4,
  parameter int CNT_W         = 8,
  parameter int ESC_THRESHOLD = 4,
  parameter int IDX_W         = (N_SINKS > 1) ? $clog2(N_SINKS) : 1
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic [N_SINKS-1:0]       fault_i,
  input  logic [N_SINKS-1:0]       mask_i,
  input  logic                     clear_i,
  output logic                     irq_o,
  output logic                     escalate_o,
  output logic [N_SINKS-1:0]       sticky_o,
  output logic                     first_valid_o,
  output logic [IDX_W-1:0]         first_idx_o,
  output logic [CNT_W-1:0]         total_cnt_o,
  output logic [N_SINKS*CNT_W-1:0] sink_cnt_o
);
  localparam int PC_W  = $clog2(N_SINKS + 1);
  localparam int SUM_W = ((CNT_W > PC_W) ? CNT_W : PC_W) + 1;
  localparam logic [SUM_W-1:0] CNT_MAX = SUM_W'({CNT_W{1'b1}});
  localparam logic [CNT_W-1:0] THR     = CNT_W'(ESC_THRESHOLD);

  typedef enum logic [1:0] {IDLE, FAULT, ESCALATED} state_e;

  state_e                          state_q, state_base, state_nxt;
  logic [N_SINKS-1:0]              f;
  logic [N_SINKS-1:0][CNT_W-1:0]   sink_cnt;
  logic [PC_W-1:0]                 pc;
  logic [SUM_W-1:0]                sum;
  logic [CNT_W-1:0]                total_nxt;
  logic [IDX_W-1:0]                low_idx, first_idx_nxt;
  logic                            first_valid_nxt;

  assign f          = fault_i & ~mask_i;
  assign sink_cnt_o = sink_cnt;

  for (genvar i = 0; i < N_SINKS; i++) begin : g_sink
    hci_parity_fault_collector_sink #(.CNT_W(CNT_W)) u_sink (
      .clk_i    (clk_i),
      .rst_ni   (rst_ni),
      .clear_i  (clear_i),
      .fault_i  (f[i]),
      .sticky_o (sticky_o[i]),
      .cnt_o    (sink_cnt[i])
    );
  end

  // Popcount and lowest set index of the effective fault vector.
  always_comb begin
    pc      = '0;
    low_idx = '0;
    for (int i = 0; i < N_SINKS; i++) pc = pc + PC_W'(f[i]);
    for (int i = N_SINKS - 1; i >= 0; i--) if (f[i]) low_idx = IDX_W'(i);
  end

  // Total: clear first, then add; clamp instead of wrapping.
  always_comb begin
    sum       = SUM_W'(clear_i ? '0 : total_cnt_o) + SUM_W'(pc);
    total_nxt = (sum > CNT_MAX) ? '1 : sum[CNT_W-1:0];
  end

  // First capture only when nothing is held after this cycle's clear.
  always_comb begin
    first_valid_nxt = clear_i ? 1'b0 : first_valid_o;
    first_idx_nxt   = clear_i ? '0   : first_idx_o;
    if (!first_valid_nxt && (f != '0)) begin
      first_valid_nxt = 1'b1;
      first_idx_nxt   = low_idx;
    end
  end

  // Next state from the post-clear state, so clear+fault lands in FAULT or
  // straight in ESCALATED. In IDLE the post-clear total is 0, so comparing
  // total_nxt there is the popcount-alone check.
  always_comb begin
    state_base = clear_i ? IDLE : state_q;
    state_nxt  = state_base;
    unique case (state_base)
      IDLE:      if (f != '0) state_nxt = (total_nxt >= THR) ? ESCALATED : FAULT;
      FAULT:     if (total_nxt >= THR) state_nxt = ESCALATED;
      ESCALATED: state_nxt = ESCALATED;
      default:   state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q       <= IDLE;
      irq_o         <= 1'b0;
      escalate_o    <= 1'b0;
      total_cnt_o   <= '0;
      first_valid_o <= 1'b0;
      first_idx_o   <= '0;
    end else begin
      state_q       <= state_nxt;
      irq_o         <= (state_nxt != IDLE);
      escalate_o    <= (state_nxt == ESCALATED);
      total_cnt_o   <= total_nxt;
      first_valid_o <= first_valid_nxt;
      first_idx_o   <= first_idx_nxt;
    end
  end
endmodule

// File: tb/tb_hci_parity_fault_collector.sv
module tb_hci_parity_fault_collector;
  localparam int N = 4;
  localparam int W = 8;

  logic         clk_i = 1'b0;
  logic         rst_ni;
  logic [N-1:0] fault_i, mask_i;
  logic         clear_i;
  logic         irq_o, escalate_o, first_valid_o;
  logic [N-1:0] sticky_o;
  logic [1:0]   first_idx_o;
  logic [W-1:0] total_cnt_o;
  logic [N*W-1:0] sink_cnt_o;

  int n_chk = 0;
  int n_err = 0;

  hci_parity_fault_collector #(.N_SINKS(N), .CNT_W(W), .ESC_THRESHOLD(4)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .fault_i(fault_i), .mask_i(mask_i),
    .clear_i(clear_i), .irq_o(irq_o), .escalate_o(escalate_o),
    .sticky_o(sticky_o), .first_valid_o(first_valid_o),
    .first_idx_o(first_idx_o), .total_cnt_o(total_cnt_o),
    .sink_cnt_o(sink_cnt_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock with the given inputs; outputs sampled 1 time unit after the edge.
  task automatic step(input logic [N-1:0] f, input logic [N-1:0] m, input logic c);
    fault_i = f; mask_i = m; clear_i = c;
    @(posedge clk_i); #1;
    fault_i = '0; mask_i = '0; clear_i = 1'b0;
  endtask

  function automatic logic [W-1:0] scnt(input int i);
    return sink_cnt_o[i*W +: W];
  endfunction

  task automatic chk_all(input string tag, input logic irq, input logic esc,
                         input logic [N-1:0] stk, input logic fv,
                         input logic [1:0] idx, input logic [W-1:0] tot);
    chk({tag, ".irq"},    32'(irq_o),         32'(irq));
    chk({tag, ".esc"},    32'(escalate_o),    32'(esc));
    chk({tag, ".sticky"}, 32'(sticky_o),      32'(stk));
    chk({tag, ".fv"},     32'(first_valid_o), 32'(fv));
    chk({tag, ".idx"},    32'(first_idx_o),   32'(idx));
    chk({tag, ".total"},  32'(total_cnt_o),   32'(tot));
  endtask

  initial begin
    rst_ni = 1'b0; fault_i = '0; mask_i = '0; clear_i = 1'b0;
    repeat (3) @(posedge clk_i);
    #1 rst_ni = 1'b1;
    chk_all("reset", 0, 0, 4'b0000, 0, 0, 0);
    chk("reset.sink_cnt", 32'(sink_cnt_o), 32'h0);

    // 1: idle for 100 cycles
    repeat (100) step(4'b0000, 4'b0000, 1'b0);
    chk_all("idle100", 0, 0, 4'b0000, 0, 0, 0);

    // 2: single fault on sink 2
    step(4'b0100, 4'b0000, 1'b0);
    chk_all("single", 1, 0, 4'b0100, 1, 2, 1);
    chk("single.cnt2", 32'(scnt(2)), 32'd1);
    chk("single.cnt0", 32'(scnt(0)), 32'd0);
    step(4'b0000, 4'b0000, 1'b0);
    chk_all("single.hold", 1, 0, 4'b0100, 1, 2, 1);
    step(4'b0000, 4'b0000, 1'b1);
    chk_all("clr1", 0, 0, 4'b0000, 0, 0, 0);
    step(4'b0000, 4'b0000, 1'b1);
    chk_all("clr_idle", 0, 0, 4'b0000, 0, 0, 0);

    // 3: threshold crossing
    step(4'b1010, 4'b0000, 1'b0);
    chk_all("thr.a", 1, 0, 4'b1010, 1, 1, 2);
    step(4'b0001, 4'b0000, 1'b0);
    chk_all("thr.b", 1, 0, 4'b1011, 1, 1, 3);
    step(4'b0001, 4'b0000, 1'b0);
    chk_all("thr.c", 1, 1, 4'b1011, 1, 1, 4);
    chk("thr.cnt0", 32'(scnt(0)), 32'd2);
    chk("thr.cnt1", 32'(scnt(1)), 32'd1);
    step(4'b0000, 4'b0000, 1'b0);
    chk_all("thr.hold", 1, 1, 4'b1011, 1, 1, 4);

    // 5: clear together with a new fault while escalated
    step(4'b1000, 4'b0000, 1'b1);
    chk_all("clrflt", 1, 0, 4'b1000, 1, 3, 1);
    chk("clrflt.cnt3", 32'(scnt(3)), 32'd1);
    chk("clrflt.cnt0", 32'(scnt(0)), 32'd0);

    // 4: saturation
    step(4'b0000, 4'b0000, 1'b1);
    for (int i = 0; i < 300; i++) step(4'b0001, 4'b0000, 1'b0);
    chk_all("sat", 1, 1, 4'b0001, 1, 0, 255);
    chk("sat.cnt0", 32'(scnt(0)), 32'd255);
    step(4'b0000, 4'b0000, 1'b1);
    chk_all("sat.clr", 0, 0, 4'b0000, 0, 0, 0);
    chk("sat.clr.cnt", 32'(sink_cnt_o), 32'h0);

    // direct IDLE -> ESCALATED on popcount alone
    step(4'b1111, 4'b0000, 1'b0);
    chk_all("direct", 1, 1, 4'b1111, 1, 0, 4);
    chk("direct.cnt", 32'(sink_cnt_o), 32'h01010101);
    step(4'b0000, 4'b0000, 1'b1);

    // 6: masking, then async reset mid-FAULT
    step(4'b0010, 4'b0000, 1'b0);
    chk_all("pre_mask", 1, 0, 4'b0010, 1, 1, 1);
    step(4'b1111, 4'b1111, 1'b0);
    chk_all("mask_all", 1, 0, 4'b0010, 1, 1, 1);
    chk("mask_all.cnt", 32'(sink_cnt_o), 32'h00000100);
    step(4'b0111, 4'b0011, 1'b0);
    chk_all("mask_part", 1, 0, 4'b0110, 1, 1, 2);
    #3 rst_ni = 1'b0;
    #1;
    chk_all("async_rst", 0, 0, 4'b0000, 0, 0, 0);
    chk("async_rst.cnt", 32'(sink_cnt_o), 32'h0);
    @(posedge clk_i); #1 rst_ni = 1'b1;
    step(4'b0000, 4'b0000, 1'b0);
    chk_all("post_rst", 0, 0, 4'b0000, 0, 0, 0);
    step(4'b1000, 4'b0000, 1'b0);
    chk_all("post_rst_flt", 1, 0, 4'b1000, 1, 3, 1);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
